pipe_perf_monitor: RTL and testbench

Synthesizable performance and hazard monitor for the 5-stage pipeline CPU. It sits directly downstream of the `cpu` core inside `comp` and consumes the core's per-cycle hazard and commit signals: stall, branch taken and target, IF/ID and ID/EX flushes, forwardA/B, and writeback valid. It accumulates saturating event counters, readable through a select port, and optionally keeps a FIFO trace of taken-branch targets. Software and benches read pipeline statistics from it instead of probing core internals hierarchically.

---
 rtl/pipe_perf_pkg.sv | 46 ++++
 rtl/perf_trace_fifo.sv | 79 +++++++
 rtl/pipe_perf_monitor.sv | 191 +++++++++++++++++++
 tb/tb_pipe_perf_monitor.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_perf_pkg.sv
// ----------------------------------------------------------------------------
// pipe_perf_pkg
// Shared definitions for the pipeline performance monitor:
//   - counter read-select codes (cnt_sel)
//   - monitor FSM state encoding
//   - bit positions of the status word returned on SEL_STATUS
//   - small helper that counts active forwarding paths
// ----------------------------------------------------------------------------
package pipe_perf_pkg;

    // Counter read-select codes driven on cnt_sel.
    typedef enum logic [2:0] {
        SEL_CYCLES   = 3'd0,
        SEL_RETIRED  = 3'd1,
        SEL_STALLS   = 3'd2,
        SEL_BRANCHES = 3'd3,
        SEL_FLUSHES  = 3'd4,
        SEL_FORWARDS = 3'd5,
        SEL_STATUS   = 3'd6,
        SEL_ZERO     = 3'd7
    } cnt_sel_e;

    // Monitor state; the encoding is visible in the status word.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } perf_state_e;

    // Number of event counters (SEL_CYCLES .. SEL_FORWARDS).
    localparam int NUM_CNT = 6;

    // Status word layout.
    localparam int STAT_OVF_BIT   = 0;
    localparam int STAT_STATE_LSB = 1;
    localparam int STAT_STATE_MSB = 2;
    localparam int STAT_OCC_LSB   = 8;
    localparam int STAT_OCC_MSB   = 15;

    // Number of operands forwarded this cycle (0..2).
    function automatic logic [1:0] fwd_count(input logic [1:0] fwd_a,
                                             input logic [1:0] fwd_b);
        return {1'b0, |fwd_a} + {1'b0, |fwd_b};
    endfunction

endpackage

// File: rtl/perf_trace_fifo.sv
// ----------------------------------------------------------------------------
// perf_trace_fifo
// Synchronous first-word-fall-through FIFO used for the branch-target trace.
// The head entry is presented on dout whenever the FIFO is non-empty; dout
// reads 0 when empty.  A pop and a push in the same cycle both succeed even
// when full, because the popped slot is the one being written.
//
// Parameters: DEPTH (power of 2, >= 2), DATA_W
// Ports:
//   clk, rstn  clock, synchronous active-low reset
//   clr        synchronous flush (empties the FIFO)
//   push, din  write request and data
//   pop        read request (ignored when empty)
//   dout       head entry
//   full, empty, count  occupancy status
// ----------------------------------------------------------------------------
module perf_trace_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_q;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; stale entries are never visible because
    // dout is gated by empty and the pointers/count are reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pipe_perf_monitor.sv
// ----------------------------------------------------------------------------
// pipe_perf_monitor
// Performance and hazard monitor for the 5-stage pipeline core.  Accumulates
// saturating event counters while in RUN and optionally records taken-branch
// targets in a trace FIFO.
//
// Build option: define PIPE_PERF_TRACE_EN to build the branch-trace FIFO,
// trace_overflow and the status-word occupancy field.  Without it the trace
// outputs are tied off (trace_empty=1, others 0).
//
// Parameters: CNT_W (counter width), TRACE_DEPTH (power of 2, >= 2)
// Ports:
//   clk, rstn                clock, synchronous active-low reset
//   start, stop, clr         control pulses (priority clr > stop > start)
//   stall, branch_taken, branch_target, flush_ifid, flush_idex,
//   forward_a, forward_b, wb_valid   per-cycle core events
//   cnt_sel / cnt_data       counter select, registered read data (1 cycle)
//   trace_rd / trace_data    trace pop, FWFT head
//   trace_empty, trace_overflow      trace status (overflow is sticky)
// ----------------------------------------------------------------------------
module pipe_perf_monitor
    import pipe_perf_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             flush_ifid,
    input  logic             flush_idex,
    input  logic [1:0]       forward_a,
    input  logic [1:0]       forward_b,
    input  logic             wb_valid,
    input  logic [2:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_data,
    input  logic             trace_rd,
    output logic [31:0]      trace_data,
    output logic             trace_empty,
    output logic             trace_overflow
);

    perf_state_e      state_q, state_d;
    logic             count_en;
    logic [CNT_W-1:0] cnt_q [NUM_CNT];
    logic [1:0]       inc   [NUM_CNT];
    logic [7:0]       occupancy;
    logic [31:0]      status_w;
    logic [CNT_W-1:0] rd_val;

    // Saturating add; inc is at most 2, so one carry bit detects overflow.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next state defaults to the current state before any branch, so
    // no path leaves state_d unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else if (stop) begin
            if (state_q == RUN) begin
                state_d = FROZEN;
            end
        end else if (start) begin
            state_d = RUN;
        end
    end

    // A stop edge is not counted, and clr wins over any increment.
    assign count_en = (state_q == RUN) && !stop && !clr;

    // ---------------- event counters ----------------
    always_comb begin
        inc[SEL_CYCLES]   = 2'd1;
        inc[SEL_RETIRED]  = {1'b0, wb_valid};
        inc[SEL_STALLS]   = {1'b0, stall};
        inc[SEL_BRANCHES] = {1'b0, branch_taken};
        inc[SEL_FLUSHES]  = {1'b0, flush_ifid | flush_idex};
        inc[SEL_FORWARDS] = fwd_count(forward_a, forward_b);
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (count_en) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= sat_add(cnt_q[i], inc[i]);
            end
        end
    end

    // ---------------- branch trace ----------------
`ifdef PIPE_PERF_TRACE_EN
    localparam int OCC_W = $clog2(TRACE_DEPTH) + 1;

    logic             push_req;
    logic             fifo_full;
    logic [OCC_W-1:0] fifo_count;
    logic             overflow_q;

    assign push_req = count_en && branch_taken;

    perf_trace_fifo #(
        .DEPTH  (TRACE_DEPTH),
        .DATA_W (32)
    ) u_trace_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr),
        .push  (push_req),
        .pop   (trace_rd),
        .din   (branch_target),
        .dout  (trace_data),
        .full  (fifo_full),
        .empty (trace_empty),
        .count (fifo_count)
    );

    // A push into a full FIFO is dropped unless a pop frees the slot.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            overflow_q <= 1'b0;
        end else if (push_req && fifo_full && !trace_rd) begin
            overflow_q <= 1'b1;
        end
    end

    assign trace_overflow = overflow_q;
    assign occupancy      = 8'(fifo_count);
`else
    logic unused_trace_in;

    assign unused_trace_in = ^{branch_target, trace_rd};
    assign trace_data      = '0;
    assign trace_empty     = 1'b1;
    assign trace_overflow  = 1'b0;
    assign occupancy       = '0;
`endif

    // ---------------- read port ----------------
    always_comb begin
        status_w                                = '0;
        status_w[STAT_OVF_BIT]                  = trace_overflow;
        status_w[STAT_STATE_MSB:STAT_STATE_LSB] = state_q;
        status_w[STAT_OCC_MSB:STAT_OCC_LSB]     = occupancy;
    end

    always_comb begin
        rd_val = '0;
        case (cnt_sel_e'(cnt_sel))
            SEL_CYCLES:   rd_val = cnt_q[SEL_CYCLES];
            SEL_RETIRED:  rd_val = cnt_q[SEL_RETIRED];
            SEL_STALLS:   rd_val = cnt_q[SEL_STALLS];
            SEL_BRANCHES: rd_val = cnt_q[SEL_BRANCHES];
            SEL_FLUSHES:  rd_val = cnt_q[SEL_FLUSHES];
            SEL_FORWARDS: rd_val = cnt_q[SEL_FORWARDS];
            SEL_STATUS:   rd_val = CNT_W'(status_w);
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_data <= '0;
        end else begin
            cnt_data <= rd_val;
        end
    end

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// ----------------------------------------------------------------------------
// tb_pipe_perf_monitor
// Drives two monitor instances from the same stimulus: a 32-bit one and a
// 4-bit one, so counter saturation is observed alongside the unsaturated
// reference.  Trace entries are tracked with a queue of expected targets.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_perf_monitor;
    import pipe_perf_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start, stop, clr;
    logic        stall, branch_taken, flush_ifid, flush_idex, wb_valid;
    logic [31:0] branch_target;
    logic [1:0]  forward_a, forward_b;
    logic [2:0]  cnt_sel;
    logic        trace_rd;

    logic [31:0] cnt_data;
    logic [31:0] trace_data;
    logic        trace_empty, trace_overflow;
    logic [3:0]  cnt_data_n;
    logic [31:0] trace_data_n;
    logic        trace_empty_n, trace_overflow_n;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    pipe_perf_monitor #(.CNT_W(32), .TRACE_DEPTH(8)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .clr(clr),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .forward_a(forward_a), .forward_b(forward_b), .wb_valid(wb_valid),
        .cnt_sel(cnt_sel), .cnt_data(cnt_data), .trace_rd(trace_rd),
        .trace_data(trace_data), .trace_empty(trace_empty),
        .trace_overflow(trace_overflow)
    );

    pipe_perf_monitor #(.CNT_W(4), .TRACE_DEPTH(8)) u_dut_narrow (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .clr(clr),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .forward_a(forward_a), .forward_b(forward_b), .wb_valid(wb_valid),
        .cnt_sel(cnt_sel), .cnt_data(cnt_data_n), .trace_rd(trace_rd),
        .trace_data(trace_data_n), .trace_empty(trace_empty_n),
        .trace_overflow(trace_overflow_n)
    );

    // Inputs change 1ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    // Present a select and wait for the registered read data.
    task automatic read_sel(input int sel);
        cnt_sel = 3'(sel);
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        start = 0; stop = 0; clr = 0; stall = 0; branch_taken = 0;
        branch_target = '0; flush_ifid = 0; flush_idex = 0; wb_valid = 0;
        forward_a = '0; forward_b = '0; cnt_sel = 3'd0; trace_rd = 0;
        repeat (3) tick();
        tests_run++;
        if ({cnt_data, trace_data, trace_empty, trace_overflow} !== {32'd0, 32'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: cnt_data=%0h trace_data=%0h empty=%0b ovf=%0b, expected 0/0/1/0",
                     cnt_data, trace_data, trace_empty, trace_overflow);
        end
        rstn = 1'b1;
        read_sel(SEL_STATUS);
        tests_run++;
        if (cnt_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_status: got %0h expected 0", cnt_data);
        end
    endtask

    task automatic test_idle_run();
        logic [31:0] expv [6];
        expv = '{32'd20, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        pulse_start();
        repeat (20) tick();
        pulse_stop();
        for (int s = 0; s < 6; s++) begin
            read_sel(s);
            tests_run++;
            if (cnt_data !== expv[s]) begin
                tests_failed++;
                $display("FAIL idle_run_sel%0d: got %0d expected %0d", s, cnt_data, expv[s]);
            end
        end
        read_sel(SEL_STATUS);
        tests_run++;
        if (cnt_data !== 32'(FROZEN) << 1) begin
            tests_failed++;
            $display("FAIL idle_run_status: got %0h expected %0h", cnt_data, 32'(FROZEN) << 1);
        end
    endtask

    task automatic test_stall_flush();
        pulse_clr();
        pulse_start();
        stall = 1'b1; repeat (3) tick(); stall = 1'b0;
        flush_idex = 1'b1; repeat (2) tick(); flush_idex = 1'b0;
        pulse_stop();
        read_sel(SEL_STALLS);
        tests_run++;
        if (cnt_data !== 32'd3) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d expected 3", cnt_data);
        end
        read_sel(SEL_FLUSHES);
        tests_run++;
        if (cnt_data !== 32'd2) begin
            tests_failed++;
            $display("FAIL flush_count: got %0d expected 2", cnt_data);
        end
        read_sel(SEL_CYCLES);
        tests_run++;
        if (cnt_data !== 32'd5) begin
            tests_failed++;
            $display("FAIL stall_flush_cycles: got %0d expected 5", cnt_data);
        end
        // Resume from FROZEN keeps earlier totals; a double flush counts once.
        pulse_start();
        flush_ifid = 1'b1; flush_idex = 1'b1; tick();
        flush_ifid = 1'b0; flush_idex = 1'b0;
        pulse_stop();
        read_sel(SEL_FLUSHES);
        tests_run++;
        if (cnt_data !== 32'd3) begin
            tests_failed++;
            $display("FAIL flush_both: got %0d expected 3", cnt_data);
        end
        read_sel(SEL_STALLS);
        tests_run++;
        if (cnt_data !== 32'd3) begin
            tests_failed++;
            $display("FAIL resume_keeps_stalls: got %0d expected 3", cnt_data);
        end
        read_sel(SEL_CYCLES);
        tests_run++;
        if (cnt_data !== 32'd6) begin
            tests_failed++;
            $display("FAIL resume_cycles: got %0d expected 6", cnt_data);
        end
    endtask

    task automatic test_forward_retire();
        pulse_clr();
        pulse_start();
        forward_a = 2'b10; forward_b = 2'b01; tick();
        forward_a = 2'b01; forward_b = 2'b00; tick();
        forward_a = 2'b00;
        wb_valid = 1'b1; repeat (4) tick(); wb_valid = 1'b0;
        pulse_stop();
        read_sel(SEL_FORWARDS);
        tests_run++;
        if (cnt_data !== 32'd3) begin
            tests_failed++;
            $display("FAIL forward_count: got %0d expected 3", cnt_data);
        end
        read_sel(SEL_RETIRED);
        tests_run++;
        if (cnt_data !== 32'd4) begin
            tests_failed++;
            $display("FAIL retired_count: got %0d expected 4", cnt_data);
        end
        read_sel(SEL_ZERO);
        tests_run++;
        if (cnt_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL sel_zero: got %0h expected 0", cnt_data);
        end
    endtask

    task automatic test_saturation();
        pulse_clr();
        pulse_start();
        repeat (20) tick();
        pulse_stop();
        read_sel(SEL_CYCLES);
        tests_run++;
        if (cnt_data_n !== 4'd15 || cnt_data !== 32'd20) begin
            tests_failed++;
            $display("FAIL cycles_saturate: narrow=%0d wide=%0d expected 15/20", cnt_data_n, cnt_data);
        end
        pulse_clr();
        read_sel(SEL_CYCLES);
        tests_run++;
        if (cnt_data_n !== 4'd0 || cnt_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL clr_cycles: narrow=%0d wide=%0d expected 0/0", cnt_data_n, cnt_data);
        end
        read_sel(SEL_STATUS);
        tests_run++;
        if (cnt_data !== 32'(IDLE)) begin
            tests_failed++;
            $display("FAIL clr_status: got %0h expected %0h", cnt_data, 32'(IDLE));
        end
        // 7 double-forward cycles reach 14; the 8th (+2) must clamp to 15.
        pulse_start();
        forward_a = 2'b11; forward_b = 2'b10; repeat (8) tick();
        forward_a = 2'b00; forward_b = 2'b00;
        pulse_stop();
        read_sel(SEL_FORWARDS);
        tests_run++;
        if (cnt_data_n !== 4'd15 || cnt_data !== 32'd16) begin
            tests_failed++;
            $display("FAIL forward_saturate: narrow=%0d wide=%0d expected 15/16", cnt_data_n, cnt_data);
        end
    endtask

`ifdef PIPE_PERF_TRACE_EN
    task automatic test_trace_overflow();
        int depth_model;
        depth_model = 0;
        exp_q.delete();
        pulse_clr();
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            branch_taken  = 1'b1;
            branch_target = 32'h100 + 32'(i);
            if (depth_model < 8) begin
                exp_q.push_back(branch_target);
                depth_model++;
            end
            tick();
        end
        branch_taken = 1'b0;
        pulse_stop();
        tests_run++;
        if (trace_overflow !== 1'b1 || trace_empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL trace_overflow_set: ovf=%0b empty=%0b expected 1/0", trace_overflow, trace_empty);
        end
        read_sel(SEL_BRANCHES);
        tests_run++;
        if (cnt_data !== 32'd9) begin
            tests_failed++;
            $display("FAIL branch_count: got %0d expected 9", cnt_data);
        end
        read_sel(SEL_STATUS);
        tests_run++;
        if (cnt_data !== 32'h805) begin
            tests_failed++;
            $display("FAIL trace_status: got %0h expected 805", cnt_data);
        end
        while (exp_q.size() > 0) begin
            tests_run++;
            if (trace_data !== exp_q[0]) begin
                tests_failed++;
                $display("FAIL trace_pop: got %0h expected %0h", trace_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            trace_rd = 1'b1; tick(); trace_rd = 1'b0;
        end
        tests_run++;
        if (trace_empty !== 1'b1 || trace_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL trace_drained: empty=%0b data=%0h expected 1/0", trace_empty, trace_data);
        end
        // Branches outside RUN are not recorded; popping empty is harmless.
        branch_taken = 1'b1; branch_target = 32'hDEAD; tick(); branch_taken = 1'b0;
        trace_rd = 1'b1; tick(); trace_rd = 1'b0;
        tests_run++;
        if (trace_empty !== 1'b1 || trace_overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL frozen_push_or_sticky: empty=%0b ovf=%0b expected 1/1", trace_empty, trace_overflow);
        end
        pulse_clr();
        tests_run++;
        if (trace_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_overflow: got %0b expected 0", trace_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] last_pop;
        last_pop = '0;
        exp_q.delete();
        pulse_clr();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            branch_taken  = 1'b1;
            branch_target = 32'h300 + 32'(i);
            exp_q.push_back(branch_target);
            tick();
        end
        // Full: push and pop together both succeed.
        branch_target = 32'h200;
        trace_rd      = 1'b1;
        tests_run++;
        if (trace_data !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL full_pop_head: got %0h expected %0h", trace_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        exp_q.push_back(branch_target);
        tick();
        branch_taken = 1'b0; trace_rd = 1'b0;
        pulse_stop();
        tests_run++;
        if (trace_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_pushpop_ovf: got %0b expected 0", trace_overflow);
        end
        while (exp_q.size() > 0) begin
            tests_run++;
            if (trace_data !== exp_q[0]) begin
                tests_failed++;
                $display("FAIL full_drain: got %0h expected %0h", trace_data, exp_q[0]);
            end
            last_pop = trace_data;
            void'(exp_q.pop_front());
            trace_rd = 1'b1; tick(); trace_rd = 1'b0;
        end
        tests_run++;
        if (last_pop !== 32'h200 || trace_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_last_entry: last=%0h empty=%0b expected 200/1", last_pop, trace_empty);
        end
    endtask
`else
    task automatic test_trace_disabled();
        pulse_clr();
        pulse_start();
        branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            branch_target = 32'h100 + 32'(i);
            tick();
        end
        branch_taken = 1'b0;
        trace_rd = 1'b1; tick(); trace_rd = 1'b0;
        pulse_stop();
        tests_run++;
        if (trace_empty !== 1'b1 || trace_data !== 32'd0 || trace_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL trace_tieoff: empty=%0b data=%0h ovf=%0b expected 1/0/0",
                     trace_empty, trace_data, trace_overflow);
        end
        read_sel(SEL_BRANCHES);
        tests_run++;
        if (cnt_data !== 32'd3) begin
            tests_failed++;
            $display("FAIL branch_count_notrace: got %0d expected 3", cnt_data);
        end
        read_sel(SEL_STATUS);
        tests_run++;
        if (cnt_data !== 32'(FROZEN) << 1) begin
            tests_failed++;
            $display("FAIL status_notrace: got %0h expected %0h", cnt_data, 32'(FROZEN) << 1);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_idle_run();
        test_stall_flush();
        test_forward_retire();
        test_saturation();
`ifdef PIPE_PERF_TRACE_EN
        test_trace_overflow();
        test_full_push_pop();
`else
        test_trace_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
